branch_cache_sa: RTL and testbench
==================================

Name: branch_cache_sa

Overview:
- N-way set-associative branch cache for the RISC-V branch prediction unit; successor to the direct-mapped branch cache.
- Index is captured from the next fetch PC. Hit, type and target are presented in the following fetch cycle.
- Adds tag-hit-aware allocation, per-set round-robin replacement and invalidation of non-branch entries.
- Valid bits are held inside the entry RAM, so a multi-cycle flush walker clears them after reset and after bpu_flush.

Parameters:
- BC_SIZE, 4, log2 of the number of sets.
- BC_WAYS, 2, associativity. Legal values are 1, 2 and 4.
- XLEN, 32, PC and target width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bpu_flush  in  1  pulse; start invalidation of all entries
- fch_pc_nxt  in  XLEN  next fetch PC; set index = fch_pc_nxt[BC_SIZE:1]
- fch_predict  in  1  capture lookup index this cycle
- fch_pc_r  in  XLEN  current fetch PC; tag = fch_pc_r[XLEN-1:BC_SIZE+1]
- fch_valid_r  in  1  valid fetch this cycle
- wrb_update_bpu  in  1  branch outcome report
- wrb_pc  in  XLEN  PC of the reporting instruction
- wrb_mispred_typ  in  1  branch type was mispredicted
- wrb_mispred_tgt  in  1  branch target was mispredicted
- wrb_branch_type  in  3  actual branch type; 3'b000 = BT_NONE (not a branch)
- wrb_target  in  XLEN  actual target
- bc_hit  out  1  valid tag match at fch_pc_r
- bc_hit_way  out  BC_WAYS  one-hot hitting way; zero on miss
- bc_pred_type  out  3  type from the hitting way
- bc_pred_target  out  XLEN  target from the hitting way, bit 0 = 0
- bc_flush_busy  out  1  flush walker active
- bc_lookups  out  32  lookup count (optional feature)
- bc_hits  out  32  hit count (optional feature)

Behaviour:
- Entry layout per way: {valid, tag[XLEN-BC_SIZE-2:0], type[2:0], target[XLEN-1:1]}. The RAM has one entry per set per way.
- Lookup:
  - At posedge, if fch_predict=1, rd_idx_r <= fch_pc_nxt[BC_SIZE:1]. Otherwise rd_idx_r holds its value.
  - All ways of set rd_idx_r are read combinationally.
  - A way hits when its valid bit is set and its tag equals the tag of fch_pc_r.
  - bc_hit = fch_valid_r & ~bc_flush_busy & (any way hits).
  - Multiple hits cannot occur; allocation forbids duplicate tags in a set.
- When bc_hit=0, bc_hit_way=0; bc_pred_type and bc_pred_target are don't-care.
- Update when wrb_update_bpu=1 and bc_flush_busy=0. Tag-match is evaluated on the wrb_pc set:
  - If wrb_mispred_typ=1 and wrb_branch_type=BT_NONE: clear the valid bit of the matching way. No match means no action. The replacement pointer is unchanged.
  - Else if (wrb_mispred_typ | wrb_mispred_tgt) and a way matches: overwrite that way in place. The pointer is unchanged.
  - Else if a mispredict is reported and no way matches: choose the victim as the lowest-numbered invalid way. If no way is invalid, use rr_ptr[set], then advance rr_ptr[set] modulo BC_WAYS. Write {1, tag, type, target} to the victim.
  - Updates with no mispredict report are ignored.
- Write-to-read visibility: a write at edge N is visible to the lookup during cycle N+1. A lookup and a write to the same set in the same cycle returns the pre-write data.
- Flush FSM states:
  - FLUSH: fl_idx walks 0..2^BC_SIZE-1, one set per cycle. All ways of set fl_idx are written invalid and rr_ptr[fl_idx] is set to 0. After the last set, go to IDLE.
  - IDLE: bpu_flush=1 sets fl_idx <= 0 and goes to FLUSH.
  - Reset forces state FLUSH with fl_idx=0.
- bc_flush_busy=1 exactly while in FLUSH.
  - Cycle counts: 2^BC_SIZE cycles after a flush request, and 2^BC_SIZE cycles after reset deassertion.
- During FLUSH: updates are dropped, bc_hit=0, and bpu_flush restarts the walk at set 0.
- Reset values: rd_idx_r=0, state=FLUSH, fl_idx=0, all rr_ptr=0, bc_hit=0, bc_hit_way=0, bc_lookups=0, bc_hits=0. RAM contents are undefined until the walk completes.
- Reset mid-flush restarts the walk at set 0.
- BC_WAYS=1: the victim is always way 0 and rr_ptr is unused.

Optional Feature:
- Macro: BC_PERF_CNT_EN.
- Defined:
  - bc_lookups increments on every cycle with fch_valid_r=1 and bc_flush_busy=0.
  - bc_hits increments on every cycle with bc_hit=1.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, and are cleared by reset only (not by flush).
- Undefined: bc_lookups and bc_hits are tied to 0 and no counter registers exist.

Test Plan:
- Reset release: bc_flush_busy=1 for exactly 16 cycles, then 0. A lookup at any PC gives bc_hit=0.
- Allocate and hit: report mispredict at wrb_pc=0x00000104, type=3'b001, target=0x00000200. Then present fch_pc_nxt=0x104 with fch_predict=1, and fch_pc_r=0x104 with fch_valid_r=1 next cycle. Required: bc_hit=1, bc_hit_way=2'b01, bc_pred_type=3'b001, bc_pred_target=0x200.
- Same-set conflict: allocate 0x104, then 0x1104 (way 1), then 0x2104. The third allocation evicts way 0 (rr_ptr=0→1), so 0x104 misses and 0x1104/0x2104 hit. A fourth allocation at 0x3104 evicts way 1.
- Invalidate: after allocating 0x104, report wrb_mispred_typ=1 with wrb_branch_type=0 at 0x104. The next lookup at 0x104 gives bc_hit=0, and bc_hit_way=0.
- Flush: pulse bpu_flush, then issue an update during the walk and re-pulse bpu_flush at walk cycle 5. Required: bc_flush_busy stays 1 for 16 cycles after the second pulse, the dropped update never hits, and all prior entries miss.
- With BC_PERF_CNT_EN defined: 10 valid fetches with 3 hits give bc_lookups=10 and bc_hits=3. Both counters still read 10 and 3 after bpu_flush.

Source files
------------

// File: rtl/branch_cache_sa.sv
// ---------------------------------------------------------------------------
// branch_cache_sa
// N-way set-associative branch cache for the RISC-V branch prediction unit.
//
// The lookup index is captured from the next fetch PC; hit, type and target
// come out combinationally in the following fetch cycle against the tag of
// the current fetch PC. Write-back reports allocate, overwrite or invalidate
// entries. Valid bits live inside the entry RAM, so a walker clears one set
// per cycle after reset and after bpu_flush.
//
// Optional feature macro: BC_PERF_CNT_EN (saturating lookup/hit counters).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   bpu_flush           pulse: invalidate all entries (restarts a running walk)
//   fch_pc_nxt          next fetch PC, set index = fch_pc_nxt[BC_SIZE:1]
//   fch_predict         capture lookup index this cycle
//   fch_pc_r            current fetch PC, tag = fch_pc_r[XLEN-1:BC_SIZE+1]
//   fch_valid_r         valid fetch this cycle
//   wrb_update_bpu      branch outcome report strobe
//   wrb_pc              PC of reporting instruction
//   wrb_mispred_typ     type mispredicted
//   wrb_mispred_tgt     target mispredicted
//   wrb_branch_type     actual type, 3'b000 = not a branch
//   wrb_target          actual target
//   bc_hit              valid tag match at fch_pc_r
//   bc_hit_way          one-hot hitting way, zero on miss
//   bc_pred_type        type of hitting way
//   bc_pred_target      target of hitting way (bit 0 = 0)
//   bc_flush_busy       flush walker active
//   bc_lookups          lookup count (0 when feature disabled)
//   bc_hits             hit count (0 when feature disabled)
// ---------------------------------------------------------------------------
module branch_cache_sa #(
  parameter int BC_SIZE = 4,
  parameter int BC_WAYS = 2,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bpu_flush,
  input  logic [XLEN-1:0]    fch_pc_nxt,
  input  logic               fch_predict,
  input  logic [XLEN-1:0]    fch_pc_r,
  input  logic               fch_valid_r,
  input  logic               wrb_update_bpu,
  input  logic [XLEN-1:0]    wrb_pc,
  input  logic               wrb_mispred_typ,
  input  logic               wrb_mispred_tgt,
  input  logic [2:0]         wrb_branch_type,
  input  logic [XLEN-1:0]    wrb_target,
  output logic               bc_hit,
  output logic [BC_WAYS-1:0] bc_hit_way,
  output logic [2:0]         bc_pred_type,
  output logic [XLEN-1:0]    bc_pred_target,
  output logic               bc_flush_busy,
  output logic [31:0]        bc_lookups,
  output logic [31:0]        bc_hits
);

  localparam int SETS = 1 << BC_SIZE;
  localparam int TW   = XLEN - BC_SIZE - 1;          // tag width
  localparam int EW   = 1 + TW + 3 + (XLEN - 1);     // entry width
  localparam int PW   = (BC_WAYS > 1) ? $clog2(BC_WAYS) : 1;
  // entry field positions: {valid, tag, type, target[XLEN-1:1]}
  localparam int V_B  = EW - 1;
  localparam int TG_L = XLEN + 2;
  localparam int TY_L = XLEN - 1;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t             r_state, w_state_next;
  logic [BC_SIZE-1:0] r_fl_idx, w_fl_idx_next;
  logic [BC_SIZE-1:0] r_rd_idx;
  logic [PW-1:0]      r_rr_ptr [SETS];
  logic [EW-1:0]      r_mem [BC_WAYS][SETS];

  logic               w_busy;
  logic [TW-1:0]      w_fch_tag, w_upd_tag;
  logic [BC_SIZE-1:0] w_upd_set;
  logic [EW-1:0]      w_rd_ent [BC_WAYS];
  logic [EW-1:0]      w_up_ent [BC_WAYS];
  logic [BC_WAYS-1:0] w_rd_hit, w_up_match;

  assign w_busy    = (r_state == ST_FLUSH);
  assign w_fch_tag = fch_pc_r[XLEN-1:BC_SIZE+1];
  assign w_upd_tag = wrb_pc[XLEN-1:BC_SIZE+1];
  assign w_upd_set = wrb_pc[BC_SIZE:1];

  // Two read ports per way: one for the fetch lookup, one for the update set.
  generate
    for (genvar gi = 0; gi < BC_WAYS; gi++) begin : g_way
      assign w_rd_ent[gi]   = r_mem[gi][r_rd_idx];
      assign w_up_ent[gi]   = r_mem[gi][w_upd_set];
      assign w_rd_hit[gi]   = w_rd_ent[gi][V_B] && (w_rd_ent[gi][V_B-1 -: TW] == w_fch_tag);
      assign w_up_match[gi] = w_up_ent[gi][V_B] && (w_up_ent[gi][V_B-1 -: TW] == w_upd_tag);
    end
  endgenerate

  // ---------------- lookup ----------------
  assign bc_hit        = fch_valid_r & ~w_busy & (|w_rd_hit);
  assign bc_hit_way    = bc_hit ? w_rd_hit : '0;
  assign bc_flush_busy = w_busy;

  // At most one way hits, so an OR of masked ways acts as the mux.
  always_comb begin
    bc_pred_type   = '0;
    bc_pred_target = '0;
    for (int w = 0; w < BC_WAYS; w++) begin
      if (w_rd_hit[w]) begin
        bc_pred_type   = bc_pred_type | w_rd_ent[w][TY_L+2:TY_L];
        bc_pred_target = bc_pred_target | {w_rd_ent[w][XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_rd_idx <= '0;
    else if (fch_predict) r_rd_idx <= fch_pc_nxt[BC_SIZE:1];
  end

  // ---------------- update decode ----------------
  logic               w_upd_en, w_mispred, w_inval, w_inv_found, w_rr_adv;
  logic [PW-1:0]      w_inv_way;
  logic [BC_WAYS-1:0] w_wr_way;
  logic [EW-1:0]      w_wr_data;

  assign w_upd_en  = wrb_update_bpu & ~w_busy;
  assign w_mispred = wrb_mispred_typ | wrb_mispred_tgt;
  assign w_inval   = wrb_mispred_typ & (wrb_branch_type == 3'b000);

  // Lowest-numbered invalid way: scan downward so the lowest index wins.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = BC_WAYS - 1; w >= 0; w--) begin
      if (!w_up_ent[w][V_B]) begin
        w_inv_found = 1'b1;
        w_inv_way   = PW'(w);
      end
    end
  end

  always_comb begin
    w_wr_way  = '0;
    w_rr_adv  = 1'b0;
    w_wr_data = {1'b1, w_upd_tag, wrb_branch_type, wrb_target[XLEN-1:1]};
    if (w_upd_en) begin
      if (w_inval) begin
        w_wr_way       = w_up_match;      // no match -> no write
        w_wr_data[V_B] = 1'b0;
      end else if (w_mispred) begin
        if (|w_up_match) begin
          w_wr_way = w_up_match;          // overwrite in place
        end else if (w_inv_found) begin
          w_wr_way[w_inv_way] = 1'b1;
        end else begin
          w_wr_way[r_rr_ptr[w_upd_set]] = 1'b1;
          w_rr_adv = 1'b1;
        end
      end
    end
  end

  // Entry RAM: no reset, the walker establishes the valid bits.
  always_ff @(posedge clk) begin
    for (int w = 0; w < BC_WAYS; w++) begin
      if (w_busy)           r_mem[w][r_fl_idx]  <= '0;
      else if (w_wr_way[w]) r_mem[w][w_upd_set] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_rr_ptr[s] <= '0;
    end else if (w_busy) begin
      r_rr_ptr[r_fl_idx] <= '0;
    end else if (w_rr_adv) begin
      r_rr_ptr[w_upd_set] <= (r_rr_ptr[w_upd_set] == PW'(BC_WAYS - 1)) ? '0
                             : r_rr_ptr[w_upd_set] + 1'b1;
    end
  end

  // ---------------- flush walker FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_FLUSH;
      r_fl_idx <= '0;
    end else begin
      r_state  <= w_state_next;
      r_fl_idx <= w_fl_idx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_fl_idx_next = r_fl_idx;
    case (r_state)
      ST_FLUSH: begin
        if (bpu_flush)                              w_fl_idx_next = '0;
        else if (r_fl_idx == BC_SIZE'(SETS - 1))    w_state_next  = ST_IDLE;
        else                                        w_fl_idx_next = r_fl_idx + 1'b1;
      end
      default: begin
        if (bpu_flush) begin
          w_state_next  = ST_FLUSH;
          w_fl_idx_next = '0;
        end
      end
    endcase
  end

  // ---------------- performance counters ----------------
`ifdef BC_PERF_CNT_EN
  logic [31:0] r_lookups, r_hits;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lookups <= '0;
      r_hits    <= '0;
    end else begin
      if (fch_valid_r && !w_busy && (r_lookups != 32'hFFFF_FFFF)) r_lookups <= r_lookups + 1'b1;
      if (bc_hit && (r_hits != 32'hFFFF_FFFF))                    r_hits    <= r_hits + 1'b1;
    end
  end
  assign bc_lookups = r_lookups;
  assign bc_hits    = r_hits;
`else
  assign bc_lookups = '0;
  assign bc_hits    = '0;
`endif

  // PC/target bits that carry no information for this cache.
  logic w_unused;
  assign w_unused = ^{fch_pc_nxt[XLEN-1:BC_SIZE+1], fch_pc_nxt[0],
                      fch_pc_r[BC_SIZE:0], wrb_pc[0], wrb_target[0]};

endmodule

// File: tb/tb_branch_cache_sa.sv
module tb_branch_cache_sa;

`ifdef BC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bpu_flush = 1'b0;
  logic [31:0] fch_pc_nxt = '0;
  logic        fch_predict = 1'b0;
  logic [31:0] fch_pc_r = '0;
  logic        fch_valid_r = 1'b0;
  logic        wrb_update_bpu = 1'b0;
  logic [31:0] wrb_pc = '0;
  logic        wrb_mispred_typ = 1'b0;
  logic        wrb_mispred_tgt = 1'b0;
  logic [2:0]  wrb_branch_type = '0;
  logic [31:0] wrb_target = '0;
  logic        bc_hit;
  logic [1:0]  bc_hit_way;
  logic [2:0]  bc_pred_type;
  logic [31:0] bc_pred_target;
  logic        bc_flush_busy;
  logic [31:0] bc_lookups;
  logic [31:0] bc_hits;

  branch_cache_sa #(.BC_SIZE(4), .BC_WAYS(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .bpu_flush(bpu_flush),
    .fch_pc_nxt(fch_pc_nxt), .fch_predict(fch_predict),
    .fch_pc_r(fch_pc_r), .fch_valid_r(fch_valid_r),
    .wrb_update_bpu(wrb_update_bpu), .wrb_pc(wrb_pc),
    .wrb_mispred_typ(wrb_mispred_typ), .wrb_mispred_tgt(wrb_mispred_tgt),
    .wrb_branch_type(wrb_branch_type), .wrb_target(wrb_target),
    .bc_hit(bc_hit), .bc_hit_way(bc_hit_way), .bc_pred_type(bc_pred_type),
    .bc_pred_target(bc_pred_target), .bc_flush_busy(bc_flush_busy),
    .bc_lookups(bc_lookups), .bc_hits(bc_hits)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          busy;
    bit          hit;
    logic [1:0]  way;
    logic [2:0]  typ;
    logic [31:0] tgt;
    bit          chk_cnt;
    logic [31:0] lk;
    logic [31:0] ht;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: a valid fetch cycle is where the DUT presents a lookup result.
  always @(negedge clk) begin
    if (fch_valid_r) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_lookup got result with no expectation pc %h", fch_pc_r);
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.name, "busy", 32'(bc_flush_busy), 32'(e.busy));
        cmp(e.name, "hit",  32'(bc_hit),        32'(e.hit));
        cmp(e.name, "way",  32'(bc_hit_way),    32'(e.way));
        if (e.hit) begin
          cmp(e.name, "type",   32'(bc_pred_type), 32'(e.typ));
          cmp(e.name, "target", bc_pred_target,    e.tgt);
        end
        if (e.chk_cnt) begin
          cmp(e.name, "lookups", bc_lookups, e.lk);
          cmp(e.name, "hits",    bc_hits,    e.ht);
        end
        $display("lookup %-12s pc=%h busy=%0d hit=%0d way=%b type=%0d tgt=%h lk=%0d ht=%0d",
                 e.name, fch_pc_r, bc_flush_busy, bc_hit, bc_hit_way, bc_pred_type,
                 bc_pred_target, bc_lookups, bc_hits);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic busy, input logic hit, input logic [1:0] way,
                      input logic [2:0] ty, input logic [31:0] tg,
                      input logic chk, input logic [31:0] lk, input logic [31:0] ht);
    exp_t e;
    e.name = nm; e.busy = busy; e.hit = hit; e.way = way; e.typ = ty; e.tgt = tg;
    e.chk_cnt = chk; e.lk = lk; e.ht = ht;
    q.push_back(e);
  endtask

  // One valid-fetch cycle at the currently captured index.
  task automatic probe(input string nm, input logic [31:0] pc, input logic busy, input logic hit,
                       input logic [1:0] way, input logic [2:0] ty, input logic [31:0] tg,
                       input logic chk, input logic [31:0] lk, input logic [31:0] ht);
    fch_pc_r    = pc;
    fch_valid_r = 1'b1;
    push(nm, busy, hit, way, ty, tg, chk, lk, ht);
    step();
    fch_valid_r = 1'b0;
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic hit,
                        input logic [1:0] way, input logic [2:0] ty, input logic [31:0] tg);
    fch_pc_nxt  = pc;
    fch_predict = 1'b1;
    step();
    fch_predict = 1'b0;
    probe(nm, pc, 1'b0, hit, way, ty, tg, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic update(input logic [31:0] pc, input logic mtyp, input logic mtgt,
                        input logic [2:0] ty, input logic [31:0] tg);
    wrb_update_bpu  = 1'b1;
    wrb_pc          = pc;
    wrb_mispred_typ = mtyp;
    wrb_mispred_tgt = mtgt;
    wrb_branch_type = ty;
    wrb_target      = tg;
    step();
    wrb_update_bpu  = 1'b0;
    $display("update pc=%h mtyp=%0d mtgt=%0d type=%0d target=%h", pc, mtyp, mtgt, ty, tg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state and release ----
    step(); step();
    probe("rst_state", 32'h40, 1'b1, 1'b0, 2'b00, 3'd0, 32'd0, 1'b1, 32'd0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 18; i++)
      probe($sformatf("rst_walk%0d", i), 32'h40, (i < 16), 1'b0, 2'b00, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0);

    // ---- allocate and hit ----
    update(32'h104, 1'b1, 1'b0, 3'd1, 32'h200);
    lookup("alloc_hit",  32'h104,  1'b1, 2'b01, 3'd1, 32'h200);
    lookup("other_set",  32'h108,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("tag_differ", 32'h1104, 1'b0, 2'b00, 3'd0, 32'd0);

    // ---- same-set conflict ----
    update(32'h1104, 1'b1, 1'b0, 3'd2, 32'h301);
    lookup("way1_hit",   32'h1104, 1'b1, 2'b10, 3'd2, 32'h300);
    update(32'h2104, 1'b0, 1'b1, 3'd3, 32'h400);
    lookup("evict_104",  32'h104,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("keep_1104",  32'h1104, 1'b1, 2'b10, 3'd2, 32'h300);
    lookup("new_2104",   32'h2104, 1'b1, 2'b01, 3'd3, 32'h400);
    update(32'h3104, 1'b1, 1'b0, 3'd4, 32'h500);
    lookup("evict_1104", 32'h1104, 1'b0, 2'b00, 3'd0, 32'd0);
    lookup("new_3104",   32'h3104, 1'b1, 2'b10, 3'd4, 32'h500);
    lookup("keep_2104",  32'h2104, 1'b1, 2'b01, 3'd3, 32'h400);
    update(32'h2104, 1'b0, 1'b1, 3'd3, 32'h480);
    lookup("overwrite",  32'h2104, 1'b1, 2'b01, 3'd3, 32'h480);
    update(32'h3104, 1'b0, 1'b0, 3'd5, 32'h998);
    lookup("no_mispred", 32'h3104, 1'b1, 2'b10, 3'd4, 32'h500);

    // ---- invalidate ----
    update(32'h3104, 1'b1, 1'b0, 3'd0, 32'h0);
    lookup("inval_3104", 32'h3104, 1'b0, 2'b00, 3'd0, 32'd0);
    update(32'h104, 1'b1, 1'b0, 3'd1, 32'h200);
    lookup("fill_inval", 32'h104,  1'b1, 2'b10, 3'd1, 32'h200);
    lookup("still_2104", 32'h2104, 1'b1, 2'b01, 3'd3, 32'h480);
    update(32'h104, 1'b1, 1'b0, 3'd0, 32'h0);
    lookup("inval_104",  32'h104,  1'b0, 2'b00, 3'd0, 32'd0);
    update(32'h5104, 1'b1, 1'b0, 3'd0, 32'h0);
    lookup("inval_none", 32'h2104, 1'b1, 2'b01, 3'd3, 32'h480);

    // ---- flush with restart and dropped update ----
    update(32'h108, 1'b1, 1'b0, 3'd1, 32'h600);
    lookup("pre_fl_108",  32'h108,  1'b1, 2'b01, 3'd1, 32'h600);
    lookup("pre_fl_2104", 32'h2104, 1'b1, 2'b01, 3'd3, 32'h480);
    for (int c = 0; c < 24; c++) begin
      bpu_flush      = (c == 0) || (c == 6);
      wrb_update_bpu = (c == 20);
      wrb_pc = 32'h10C; wrb_mispred_typ = 1'b1; wrb_mispred_tgt = 1'b0;
      wrb_branch_type = 3'd2; wrb_target = 32'h700;
      fch_pc_r = 32'h2104;
      if (c >= 1) begin
        fch_valid_r = 1'b1;
        push($sformatf("flush_c%0d", c), (c <= 22), 1'b0, 2'b00, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      end
      step();
    end
    bpu_flush = 1'b0; wrb_update_bpu = 1'b0; fch_valid_r = 1'b0;
    lookup("post_fl_2104", 32'h2104, 1'b0, 2'b00, 3'd0, 32'd0);
    lookup("post_fl_108",  32'h108,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("dropped_10C",  32'h10C,  1'b0, 2'b00, 3'd0, 32'd0);

    // ---- performance counters ----
    reset = 1'b1;
    probe("perf_rst", 32'h0, 1'b1, 1'b0, 2'b00, 3'd0, 32'd0, 1'b1, 32'd0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) step();
    update(32'h104, 1'b1, 1'b0, 3'd1, 32'h200);
    update(32'h108, 1'b1, 1'b0, 3'd2, 32'h280);
    lookup("pf_h1",  32'h104,  1'b1, 2'b01, 3'd1, 32'h200);
    lookup("pf_m1",  32'h200,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("pf_h2",  32'h108,  1'b1, 2'b01, 3'd2, 32'h280);
    lookup("pf_m2",  32'h300,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("pf_m3",  32'h1104, 1'b0, 2'b00, 3'd0, 32'd0);
    lookup("pf_h3",  32'h104,  1'b1, 2'b01, 3'd1, 32'h200);
    lookup("pf_m4",  32'h400,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("pf_m5",  32'h500,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("pf_m6",  32'h600,  1'b0, 2'b00, 3'd0, 32'd0);
    lookup("pf_m7",  32'h700,  1'b0, 2'b00, 3'd0, 32'd0);
    bpu_flush = 1'b1;
    step();
    bpu_flush = 1'b0;
    for (int k = 0; k < 17; k++)
      probe($sformatf("pf_flush%0d", k), 32'h700, (k < 16), 1'b0, 2'b00, 3'd0, 32'd0,
            1'b1, PERF ? 32'd10 : 32'd0, PERF ? 32'd3 : 32'd0);

    step(); step();
    cmp("drain", "pending", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
